// File: rtl/dstack_spill_ctrl_pkg.sv
// Shared encodings for the data-stack spill/fill sequencer.
// Movement codes are also produced by the instruction decoder.
package dstack_spill_ctrl_pkg;

  localparam logic [1:0] MOVE_NONE = 2'b00;
  localparam logic [1:0] MOVE_PUSH = 2'b01;
  localparam logic [1:0] MOVE_POP1 = 2'b10;
  localparam logic [1:0] MOVE_POP2 = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SPILL = 2'd1;
  localparam state_t ST_FILL  = 2'd2;

endpackage

// File: rtl/dstack_occupancy.sv
// On-chip stack occupancy counter.
// Sums core and spill/fill deltas, saturating at 0 and DEPTH.
module dstack_occupancy
  import dstack_spill_ctrl_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] move,
  input  logic       move_en,
  input  logic       spill_done,
  input  logic       fill_done,
  output logic [6:0] count,
  output logic       full,
  output logic       has1,
  output logic       has2
);

  localparam logic signed [8:0] TOP = 9'(DEPTH);

  logic signed [8:0] core_d;
  logic signed [8:0] mem_d;
  logic signed [8:0] sum;
  logic [6:0]        nxt;

  always_comb begin
    core_d = '0;
    if (move_en) begin
      case (move)
        MOVE_PUSH: core_d = 9'sd1;
        MOVE_POP1: core_d = -9'sd1;
        MOVE_POP2: core_d = -9'sd2;
        default:   core_d = '0;
      endcase
    end
    mem_d = '0;
    if (fill_done)
      mem_d = 9'sd1;
    else if (spill_done)
      mem_d = -9'sd1;
    sum = $signed({2'b00, count}) + core_d + mem_d;
    // Underflow with memory empty clamps to zero
    if (sum < 0)
      nxt = '0;
    else if (sum > TOP)
      nxt = TOP[6:0];
    else
      nxt = sum[6:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      count <= '0;
    else
      count <= nxt;
  end

  assign full = (count == TOP[6:0]);
  assign has1 = (count != 7'd0);
  assign has2 = (count > 7'd1);

endmodule

// File: rtl/dstack_spill_ctrl.sv
// Data-stack spill/fill sequencer between the on-chip
// register stack and main memory.
module dstack_spill_ctrl
  import dstack_spill_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int HIGH_MARK  = 56,
  parameter int LOW_MARK   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_move,
  input  logic                  req_deep,
  input  logic [5:0]            req_depth,
  output logic                  halt,
  input  logic                  sp_load,
  input  logic [WORD_WIDTH-1:0] sp_value,
  input  logic [WORD_WIDTH-1:0] bot_data,
  output logic                  bot_pop,
  output logic                  bot_push,
  output logic [WORD_WIDTH-1:0] bot_wdata,
  output logic                  mem_wr_req,
  output logic [WORD_WIDTH-1:0] mem_wr_addr,
  output logic [WORD_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_ack,
  output logic                  mem_rd_req,
  output logic [WORD_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [WORD_WIDTH-1:0] mem_rd_data,
  output logic [6:0]            count,
  output logic                  fault
);

  localparam logic [6:0] HI = 7'(HIGH_MARK);
  localparam logic [6:0] LO = 7'(LOW_MARK);
  localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

  state_t                state;
  logic                  rd_sent;
  logic [WORD_WIDTH-1:0] mem_sp;
  logic [WORD_WIDTH-1:0] mem_count;

  logic full, has1, has2;
  logic mem_has, pop_short, underflow;
  logic spill_done, fill_done;

  assign mem_has   = (mem_count != '0);
  assign pop_short = (req_move == MOVE_POP1 && !has1) ||
                     (req_move == MOVE_POP2 && !has2);

  assign halt = (req_move == MOVE_PUSH && full) ||
                (pop_short && mem_has) ||
                (req_deep && {1'b0, req_depth} >= count && mem_has);

  assign underflow = pop_short && !mem_has && !halt;

  assign spill_done = (state == ST_SPILL) && mem_wr_ack;
  // The read pulse must go out before a return is accepted
  assign fill_done  = (state == ST_FILL) && rd_sent && mem_rd_valid;

  assign mem_wr_req  = (state == ST_SPILL);
  assign mem_wr_addr = mem_sp;
  assign mem_wr_data = bot_data;
  assign mem_rd_req  = (state == ST_FILL) && !rd_sent;
  assign mem_rd_addr = mem_sp - ONE;
  assign bot_pop     = spill_done;
  assign bot_push    = fill_done;
  assign bot_wdata   = mem_rd_data;

  dstack_occupancy #(
    .DEPTH(DEPTH)
  ) u_occ (
    .clk       (clk),
    .reset_n   (reset_n),
    .move      (req_move),
    .move_en   (!halt),
    .spill_done(spill_done),
    .fill_done (fill_done),
    .count     (count),
    .full      (full),
    .has1      (has1),
    .has2      (has2)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rd_sent   <= 1'b0;
      mem_sp    <= '0;
      mem_count <= '0;
      fault     <= 1'b0;
    end else begin
      fault <= underflow;
      case (state)
        ST_IDLE: begin
          rd_sent <= 1'b0;
          if (sp_load) begin
            mem_sp    <= sp_value;
            mem_count <= '0;
          end
          if (count >= HI)
            state <= ST_SPILL;
          else if (!sp_load && count < LO && mem_has)
            state <= ST_FILL;
        end
        ST_SPILL: begin
          if (mem_wr_ack) begin
            mem_sp    <= mem_sp + ONE;
            mem_count <= mem_count + ONE;
            state     <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (!rd_sent) begin
            rd_sent <= 1'b1;
          end else if (mem_rd_valid) begin
            mem_sp    <= mem_sp - ONE;
            mem_count <= mem_count - ONE;
            rd_sent   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dstack_spill_ctrl.md
# dstack_spill_ctrl

Spill/fill sequencer for the data stack. The top DEPTH entries of the stack live in the on-chip register stack, and everything deeper lives in main memory. The block tracks on-chip occupancy and spills the bottom entry to memory when the stack runs high. It fills from memory when the stack runs low, and raises `halt` to the stack datapath when a requested movement or deep access cannot be served this cycle.

## Interface
- WORD_WIDTH, 32, data and address width
- DEPTH, 64, on-chip stack entries; a 6-bit index addresses all of them
- HIGH_MARK, 56, spill while count >= HIGH_MARK
- LOW_MARK, 8, fill while count < LOW_MARK and mem_count != 0

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_move  in  2  requested movement, decoded from the instruction: 00 none, 01 push 1, 10 pop 1, 11 pop 2
- req_deep  in  1  instruction reads a deep slot (copy/rotate)
- req_depth  in  6  slot index for req_deep (0 = top)
- halt  out  1  stall; the datapath applies no movement while high
- sp_load  in  1  load memory stack pointer
- sp_value  in  WORD_WIDTH  new memory stack pointer; also clears mem_count
- bot_data  in  WORD_WIDTH  current bottom entry of the on-chip stack
- bot_pop  out  1  remove bottom entry (spill done)
- bot_push  out  1  insert bot_wdata below bottom (fill done)
- bot_wdata  out  WORD_WIDTH  fill data
- mem_wr_req, mem_wr_addr, mem_wr_data  out  1/WORD_WIDTH/WORD_WIDTH  spill write
- mem_wr_ack  in  1  write accepted
- mem_rd_req, mem_rd_addr  out  1/WORD_WIDTH  fill read
- mem_rd_valid, mem_rd_data  in  1/WORD_WIDTH  read return
- count  out  7  on-chip occupancy, 0..DEPTH
- fault  out  1  one-cycle pulse on underflow with memory empty

## Operation
- State is held in four registers:
  - count (7 bits)
  - mem_sp (WORD_WIDTH bits): next free memory word address; the stack grows upward.
  - mem_count (WORD_WIDTH bits): number of entries currently spilled.
  - FSM state: IDLE, SPILL, FILL.
- IDLE:
  - If count >= HIGH_MARK, go to SPILL.
  - Else if count < LOW_MARK and mem_count != 0, go to FILL.
  - Else stay in IDLE. SPILL has priority over FILL.
- SPILL:
  - mem_wr_req=1, mem_wr_addr=mem_sp, mem_wr_data=bot_data.
  - On mem_wr_ack: bot_pop=1, count-=1, mem_sp+=1, mem_count+=1, then go to IDLE.
- FILL:
  - mem_rd_req is asserted for one cycle with mem_rd_addr=mem_sp-1.
  - The block then waits for mem_rd_valid.
  - On mem_rd_valid: bot_push=1, bot_wdata=mem_rd_data, count+=1, mem_sp-=1, mem_count-=1, then go to IDLE.
- halt is asserted when any of the following holds:
  - push requested and count == DEPTH
  - pop n requested and count < n and mem_count != 0
  - req_deep and req_depth >= count and mem_count != 0
- When halt is low, count is updated by req_move (+1/-1/-2). This is combined with the same-cycle spill/fill delta, so a simultaneous core pop and fill completion nets to 0.
- Underflow: a pop n with count < n and mem_count == 0 does not halt.
  - fault pulses for one cycle.
  - count saturates at 0.
- sp_load:
  - Accepted only in IDLE; in SPILL/FILL it is held off until the state returns to IDLE.
  - Sets mem_sp=sp_value and mem_count=0.
  - On-chip count is unchanged.

## Timing
- Reset values:
  - count=0, mem_sp=0, mem_count=0, state=IDLE.
  - All req/pop/push outputs 0, halt=0, fault=0.
- halt is combinational from the registered count/mem_count and the current-cycle request inputs. halt has no path from bot_data or mem data.
- Spill latency: request to bot_pop is ≥1 cycle, the cycle of mem_wr_ack. mem_wr_req and its address/data stay stable until ack.
- Fill latency: mem_rd_req pulse, then bot_push in the mem_rd_valid cycle. Arbitrary gap allowed.
- count settles the cycle after any movement. Threshold evaluation in IDLE uses the registered count, so re-entering SPILL/FILL takes ≥1 IDLE cycle.
- Reset mid-transaction drops the request immediately. The memory side must discard a late ack or valid.

## Structure
- A shared package holds:
  - the movement encoding constants MOVE_NONE/PUSH/POP1/POP2 (also used by the decoder feeding dstack_control);
  - the state enum.
- One sub-module is natural: dstack_occupancy. It is a saturating counter taking a core delta and a spill/fill delta, and produces count, full, and has_n flags.

## Test plan
- Push 56 from empty (memory ack immediate) -> SPILL entered. mem_wr_addr=0, mem_wr_data=bottom value, count returns to 55, mem_count=1.
- count=64, push requested with ack withheld for 5 cycles -> halt=1 for those cycles. Count stays 64 until ack, then the push proceeds.
- count=7, mem_count=3, mem_sp=0x103 -> mem_rd_addr=0x102. After valid with data 0xDEAD: bot_push with 0xDEAD, count=8, mem_sp=0x102.
- count=1, mem_count=2, pop 2 requested -> halt until the fill completes, then the pop is applied and count=0.
- count=0, mem_count=0, pop 1 -> no halt, fault pulses once, count stays 0.
- Reset asserted in SPILL with ack pending -> next cycle all outputs at reset values. A late ack causes no bot_pop.
